// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
// Request/line bundle between a UART transmit client and uart_transmitter.
//   tx_start        request strobe, sampled on clk1
//   parity_type     0 = even, 1 = odd; sampled with the request
//   parallel_datain word to send; sampled with the request
//   serialdata_out  serial line, idles high
//   tx_done         high when idle, low while a frame is in flight
//   busy            high when a request cannot be accepted this cycle
//   baudratetx      one-cycle baud tick
// master = client side, slave = transmitter side.
interface uart_transmitter_if #(
  parameter int Data_length = 8
);
  logic                   tx_start;
  logic                   parity_type;
  logic [Data_length-1:0] parallel_datain;
  logic                   serialdata_out;
  logic                   tx_done;
  logic                   busy;
  logic                   baudratetx;

  modport master (
    output tx_start, parity_type, parallel_datain,
    input  serialdata_out, tx_done, busy, baudratetx
  );

  modport slave (
    input  tx_start, parity_type, parallel_datain,
    output serialdata_out, tx_done, busy, baudratetx
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Serialises one parallel word per request into a length-prefixed frame:
//   4-bit header L (MSB first), start 0, data LSB first, optional parity, stop 1.
//   L = Data_length + parity_en + 2; a whole frame spans 4 + L bit periods.
// Ports:
//   clk1   system clock
//   rst    asynchronous reset, active high
//   tx_if  uart_transmitter_if.slave (request, data, line, status, baud tick)
// Optional build macro TX_HOLD_EN: adds a one-entry holding register so a
// request arriving mid-frame is queued and sent back-to-back.
module uart_transmitter #(
  parameter int Data_length = 8,
  parameter int parity_en   = 1,
  parameter int baud_rate   = 1152000,
  parameter int fqr         = 50000000,
  parameter int clk_div     = fqr / baud_rate
) (
  input  logic clk1,
  input  logic rst,
  uart_transmitter_if.slave tx_if
);

  typedef enum logic [2:0] {IDLE, HEADER, START, DATA, PARITY, STOP} state_t;

  localparam int       CNT_W     = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int       FRAME_LEN = Data_length + parity_en + 2;
  localparam logic [3:0] HDR     = 4'(FRAME_LEN);
`ifdef TX_HOLD_EN
  localparam logic BUSY_ON_ACCEPT = 1'b0;
`else
  localparam logic BUSY_ON_ACCEPT = 1'b1;
`endif

  state_t                 state;
  logic [CNT_W-1:0]       baud_cnt;
  logic                   tick;
  logic [Data_length-1:0] data_sr;
  logic                   parity_bit;
  logic [3:0]             bit_cnt;
  logic                   serial_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   stop_end;
`ifdef TX_HOLD_EN
  logic [Data_length-1:0] hold_data;
  logic                   hold_type;
  logic                   hold_full;
`endif

  function automatic logic calc_parity(input logic [Data_length-1:0] d,
                                       input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  assign tick     = (baud_cnt == CNT_W'(clk_div - 1));
  assign stop_end = (state == STOP) && tick && (bit_cnt == 4'd1);

  assign tx_if.serialdata_out = serial_q;
  assign tx_if.tx_done        = done_q;
  assign tx_if.busy           = busy_q;
  assign tx_if.baudratetx     = tick;

  // Free-running baud counter; tick is a clock enable, never a clock.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  // Frame sequencer. The request is accepted on any edge, but the line only
  // changes on tick edges. In STOP, bit_cnt=0 means the stop bit has not yet
  // been driven and bit_cnt=1 means the next tick closes the frame.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_sr    <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      serial_q   <= 1'b1;
      done_q     <= 1'b1;
      busy_q     <= 1'b0;
`ifdef TX_HOLD_EN
      hold_data  <= '0;
      hold_type  <= 1'b0;
      hold_full  <= 1'b0;
`endif
    end else begin
`ifdef TX_HOLD_EN
      // Capture a mid-frame request; the frame-closing edge is handled below.
      if (state != IDLE && !stop_end && tx_if.tx_start && !hold_full) begin
        hold_data <= tx_if.parallel_datain;
        hold_type <= tx_if.parity_type;
        hold_full <= 1'b1;
        busy_q    <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (tx_if.tx_start && !busy_q) begin
            data_sr    <= tx_if.parallel_datain;
            parity_bit <= calc_parity(tx_if.parallel_datain, tx_if.parity_type);
            bit_cnt    <= '0;
            done_q     <= 1'b0;
            busy_q     <= BUSY_ON_ACCEPT;
            state      <= HEADER;
          end
        end
        HEADER: begin
          if (tick) begin
            serial_q <= HDR[~bit_cnt[1:0]];
            if (bit_cnt == 4'd3) begin
              bit_cnt <= '0;
              state   <= START;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        START: begin
          if (tick) begin
            serial_q <= 1'b0;
            bit_cnt  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            serial_q <= data_sr[0];
            data_sr  <= data_sr >> 1;
            if (bit_cnt == 4'(Data_length - 1)) begin
              bit_cnt <= '0;
              state   <= (parity_en != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            serial_q <= parity_bit;
            bit_cnt  <= '0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == 4'd0) begin
              serial_q <= 1'b1;
              bit_cnt  <= 4'd1;
            end else begin
              bit_cnt <= '0;
`ifdef TX_HOLD_EN
              if (hold_full) begin
                data_sr    <= hold_data;
                parity_bit <= calc_parity(hold_data, hold_type);
                hold_full  <= 1'b0;
                busy_q     <= 1'b0;
                state      <= HEADER;
              end else if (tx_if.tx_start) begin
                // busy is low here, so this request must not be lost.
                data_sr    <= tx_if.parallel_datain;
                parity_bit <= calc_parity(tx_if.parallel_datain, tx_if.parity_type);
                busy_q     <= 1'b0;
                state      <= HEADER;
              end else begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
              end
`else
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
